// File: rtl/transport_depacketizer_if.sv
// Byte-stream and delivery bundle for the receive-side transport depacketizer.
// slave  : the depacketizer's view (consumes rx bytes, produces ctrl/audio words)
// master : the surrounding logic's view (drives rx bytes, consumes ctrl/audio words)
interface transport_depacketizer_if;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] ctrl_word;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic [15:0] audio_sample;
    logic        audio_valid;
    logic        audio_ready;
    logic        pkt_err;
    logic [7:0]  err_count;

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  ctrl_ready,
        input  audio_ready,
        output rx_ready,
        output ctrl_word,
        output ctrl_valid,
        output audio_sample,
        output audio_valid,
        output pkt_err,
        output err_count
    );

    modport master (
        output rx_byte,
        output rx_valid,
        output ctrl_ready,
        output audio_ready,
        input  rx_ready,
        input  ctrl_word,
        input  ctrl_valid,
        input  audio_sample,
        input  audio_valid,
        input  pkt_err,
        input  err_count
    );
endinterface

// File: rtl/transport_depacketizer.sv
// Receive-side transport depacketizer.
// Takes fixed-size byte packets, classifies them by header (0x40 control,
// 0x80 audio, 0x00 idle filler), reassembles the 16-bit payload and releases
// it only once the whole packet has been accepted. Bad packets are consumed
// to their last byte, then flagged with a one-cycle pkt_err and counted in a
// saturating err_count.
// Optional feature macro: PAD_CHECK_EN -- when defined, a nonzero padding
// byte turns the packet into a dropped packet; when undefined padding is
// ignored and only an unknown header causes a drop.
module transport_depacketizer #(
    parameter int PKT_BYTES     = 16,
    parameter int AUDIO_SAMPLES = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    transport_depacketizer_if.slave bus
);

    localparam int IDX_W  = $clog2(PKT_BYTES);
    localparam int SIDX_W = (AUDIO_SAMPLES > 1) ? $clog2(AUDIO_SAMPLES) : 1;

    localparam logic [IDX_W-1:0]  IDX_ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0]  IDX_TWO     = IDX_W'(2);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(PKT_BYTES - 1);
    localparam logic [IDX_W-1:0]  CTRL_LAST   = IDX_W'(2);
    localparam logic [IDX_W-1:0]  AUDIO_LAST  = IDX_W'(2 * AUDIO_SAMPLES);
    localparam logic [SIDX_W-1:0] SIDX_ONE    = SIDX_W'(1);
    localparam logic [SIDX_W-1:0] SAMPLE_LAST = SIDX_W'(AUDIO_SAMPLES - 1);

    localparam logic [7:0] HDR_FILL  = 8'h00;
    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;

    typedef enum logic [2:0] {
        HDR,
        PAYLOAD,
        PAD,
        DROP,
        DLV_CTRL,
        DLV_AUDIO
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  byteIdx;
    logic              isAudio;
    logic              rxReadyQ;
    logic [15:0]       ctrlHold;
    logic [15:0]       sampleBuf [AUDIO_SAMPLES];
    logic [SIDX_W-1:0] outIdx;

    logic              accept;
    logic [IDX_W-1:0]  payLast;
    logic [IDX_W-1:0]  payOff;
    logic [SIDX_W-1:0] slot;
    logic              padBadNow;
    logic              pktEnd;
    logic              pktBad;
    logic [15:0]       ctrlNext;
    logic [15:0]       firstSample;

    // Saturating increment for the dropped-packet counter.
    function automatic logic [7:0] satInc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // rx_ready is a registered flag, forced low while reset is held so the
    // link never sees the block as ready during the reset cycle.
    assign bus.rx_ready = rxReadyQ & ~reset;

    assign accept  = bus.rx_valid & rxReadyQ;
    assign payLast = isAudio ? AUDIO_LAST : CTRL_LAST;
    assign payOff  = byteIdx - IDX_ONE;
    assign slot    = SIDX_W'(payOff >> 1);

`ifdef PAD_CHECK_EN
    assign padBadNow = (state == PAD) && (bus.rx_byte != 8'h00);
`else
    assign padBadNow = 1'b0;
`endif

    // The final byte of the packet (index PKT_BYTES-1) is being accepted.
    assign pktEnd = accept && (byteIdx == LAST_IDX) &&
                    ((state == PAYLOAD) || (state == PAD) || (state == DROP));
    assign pktBad = (state == DROP) || padBadNow;

    // Merge the byte arriving this cycle into the values handed to the
    // delivery registers, so a packet with no padding still delivers the
    // complete word/sample on the cycle after its last byte.
    always_comb begin
        ctrlNext    = ctrlHold;
        firstSample = sampleBuf[0];
        if (state == PAYLOAD) begin
            if (byteIdx == IDX_ONE) ctrlNext[15:8] = bus.rx_byte;
            if (byteIdx == IDX_TWO) begin
                ctrlNext[7:0]    = bus.rx_byte;
                firstSample[7:0] = bus.rx_byte;
            end
        end
    end

    // Capture audio payload bytes, hi then lo, into the sample buffer.
    always_ff @(posedge clk) begin
        if (accept && (state == PAYLOAD) && isAudio) begin
            if (byteIdx[0]) sampleBuf[slot][15:8] <= bus.rx_byte;
            else            sampleBuf[slot][7:0]  <= bus.rx_byte;
        end
    end

    // Packet framing FSM with registered delivery and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= HDR;
            byteIdx          <= '0;
            isAudio          <= 1'b0;
            rxReadyQ         <= 1'b1;
            ctrlHold         <= 16'h0000;
            outIdx           <= '0;
            bus.ctrl_word    <= 16'h0000;
            bus.ctrl_valid   <= 1'b0;
            bus.audio_sample <= 16'h0000;
            bus.audio_valid  <= 1'b0;
            bus.pkt_err      <= 1'b0;
            bus.err_count    <= 8'h00;
        end else begin
            bus.pkt_err <= 1'b0;

            case (state)
                HDR: begin
                    if (accept) begin
                        if ((bus.rx_byte == HDR_CTRL) || (bus.rx_byte == HDR_AUDIO)) begin
                            state   <= PAYLOAD;
                            isAudio <= (bus.rx_byte == HDR_AUDIO);
                            byteIdx <= IDX_ONE;
                        end else if (bus.rx_byte != HDR_FILL) begin
                            state   <= DROP;
                            byteIdx <= IDX_ONE;
                        end
                    end
                end

                PAYLOAD: begin
                    if (accept) begin
                        if (!isAudio) ctrlHold <= ctrlNext;
                        byteIdx <= byteIdx + IDX_ONE;
                        if (byteIdx == payLast) state <= PAD;
                    end
                end

                PAD: begin
                    if (accept) begin
                        byteIdx <= byteIdx + IDX_ONE;
                        if (padBadNow) state <= DROP;
                    end
                end

                DROP: begin
                    if (accept) byteIdx <= byteIdx + IDX_ONE;
                end

                DLV_CTRL: begin
                    if (bus.ctrl_ready) begin
                        bus.ctrl_valid <= 1'b0;
                        rxReadyQ       <= 1'b1;
                        state          <= HDR;
                    end
                end

                DLV_AUDIO: begin
                    if (bus.audio_ready) begin
                        if (outIdx == SAMPLE_LAST) begin
                            bus.audio_valid <= 1'b0;
                            rxReadyQ        <= 1'b1;
                            state           <= HDR;
                        end else begin
                            outIdx           <= outIdx + SIDX_ONE;
                            bus.audio_sample <= sampleBuf[outIdx + SIDX_ONE];
                        end
                    end
                end

                default: state <= HDR;
            endcase

            // End of packet overrides the per-state stepping above: the byte
            // index returns to zero and the packet is either delivered or
            // reported as dropped, never both.
            if (pktEnd) begin
                byteIdx <= '0;
                if (pktBad) begin
                    state         <= HDR;
                    bus.pkt_err   <= 1'b1;
                    bus.err_count <= satInc(bus.err_count);
                end else if (isAudio) begin
                    state            <= DLV_AUDIO;
                    outIdx           <= '0;
                    bus.audio_sample <= firstSample;
                    bus.audio_valid  <= 1'b1;
                    rxReadyQ         <= 1'b0;
                end else begin
                    state          <= DLV_CTRL;
                    bus.ctrl_word  <= ctrlNext;
                    bus.ctrl_valid <= 1'b1;
                    rxReadyQ       <= 1'b0;
                end
            end
        end
    end

endmodule
